// File: rtl/in_pass_n_filtered.sv
// in_pass_n_filtered
// N-channel pad-input pass cell for IO tiles. Each channel can bypass
// combinationally or go through a synchroniser, an optional glitch filter
// and a registered edge detector that emits one-cycle RISE/FALL pulses.
// CFG_* bits come from configuration memory and may change at run time.
//
// There is no valid/ready handshake on this block: I is sampled every CLK
// edge, and O/RISE/FALL are plain per-cycle levels with no back-pressure.
module in_pass_n_filtered #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,  // legal range 1..4
  parameter int FILT_BITS   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     I,
  input  logic [WIDTH-1:0]     CFG_REG,
  input  logic [WIDTH-1:0]     CFG_FILT_EN,
  input  logic [FILT_BITS-1:0] CFG_FILT_LEN,
  output logic [WIDTH-1:0]     O,
  output logic [WIDTH-1:0]     RISE,
  output logic [WIDTH-1:0]     FALL
);

  // Synchroniser chain: sync_q[0] samples the pad, the last stage is the
  // settled value the filter looks at.
  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     s_sync;

  // Filter state per channel.
  logic [WIDTH-1:0]     f_q;
  logic [WIDTH-1:0]     f_next;
  logic [FILT_BITS-1:0] cnt_q    [WIDTH];
  logic [FILT_BITS-1:0] cnt_next [WIDTH];

  // Registered edge pulses.
  logic [WIDTH-1:0]     rise_q;
  logic [WIDTH-1:0]     fall_q;

  // Shift pad inputs through the synchroniser; cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= I;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Next filtered value and counter per channel. The counter only runs while
  // the synchronised input disagrees with the filtered value; acceptance uses
  // >= so lowering the length below the current count still accepts, and the
  // counter can never step past the largest length, so it never wraps.
  always_comb begin
    for (int n = 0; n < WIDTH; n++) begin
      f_next[n]   = f_q[n];
      cnt_next[n] = '0;
      if (!CFG_FILT_EN[n]) begin
        f_next[n]   = s_sync[n];
        cnt_next[n] = '0;
      end else if (s_sync[n] == f_q[n]) begin
        cnt_next[n] = '0;
      end else if (cnt_q[n] >= CFG_FILT_LEN) begin
        f_next[n]   = s_sync[n];
        cnt_next[n] = '0;
      end else begin
        cnt_next[n] = FILT_BITS'(cnt_q[n] + 1'b1);
      end
    end
  end

  // Filter state and edge pulses. The pulses are derived from the same
  // F -> F_next transition that updates O, so they line up with the first
  // cycle O shows the new value. Reset clears F directly without going
  // through f_next, so it never produces a pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      f_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      f_q    <= f_next;
      rise_q <= ~f_q & f_next;
      fall_q <= f_q & ~f_next;
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= cnt_next[n];
      end
    end
  end

  // Output mux. The registered path keeps running in bypass mode, so turning
  // CFG_REG on shows the current F at once; pulses are masked while bypassed.
  assign O    = (CFG_REG & f_q) | (~CFG_REG & I);
  assign RISE = rise_q & CFG_REG;
  assign FALL = fall_q & CFG_REG;

endmodule

// File: tb/tb_in_pass_n_filtered.sv
// Directed testbench for in_pass_n_filtered (WIDTH=8, SYNC_STAGES=2,
// FILT_BITS=4). Inputs change 1 ns after a rising edge; outputs are sampled
// at that same point, i.e. reflecting the state after the edge.
module tb_in_pass_n_filtered;

  logic       CLK;
  logic       RST;
  logic [7:0] I;
  logic [7:0] CFG_REG;
  logic [7:0] CFG_FILT_EN;
  logic [3:0] CFG_FILT_LEN;
  logic [7:0] O;
  logic [7:0] RISE;
  logic [7:0] FALL;

  int n_checks = 0;
  int n_fail   = 0;

  in_pass_n_filtered #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .FILT_BITS  (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .I           (I),
    .CFG_REG     (CFG_REG),
    .CFG_FILT_EN (CFG_FILT_EN),
    .CFG_FILT_LEN(CFG_FILT_LEN),
    .O           (O),
    .RISE        (RISE),
    .FALL        (FALL)
  );

  // Clock and reset defaults
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reset state, release, first rise and fall with filter off.
  task automatic test_reset();
    RST = 1'b1; I = 8'hFF; CFG_REG = 8'hFF; CFG_FILT_EN = 8'h00; CFG_FILT_LEN = 4'd0;
    #2;
    n_checks++; if (O !== 8'h00) begin n_fail++; $display("FAIL reset_o: got %h expected %h", O, 8'h00); end
    n_checks++; if (RISE !== 8'h00) begin n_fail++; $display("FAIL reset_rise: got %h expected %h", RISE, 8'h00); end
    n_checks++; if (FALL !== 8'h00) begin n_fail++; $display("FAIL reset_fall: got %h expected %h", FALL, 8'h00); end
    tick(); tick();
    n_checks++; if (O !== 8'h00) begin n_fail++; $display("FAIL reset_held_o: got %h expected %h", O, 8'h00); end
    RST = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      n_checks++;
      if (O !== ((t >= 3) ? 8'hFF : 8'h00)) begin
        n_fail++; $display("FAIL release_o t=%0d: got %h expected %h", t, O, ((t >= 3) ? 8'hFF : 8'h00));
      end
      n_checks++;
      if (RISE !== ((t == 3) ? 8'hFF : 8'h00)) begin
        n_fail++; $display("FAIL release_rise t=%0d: got %h expected %h", t, RISE, ((t == 3) ? 8'hFF : 8'h00));
      end
      n_checks++;
      if (FALL !== 8'h00) begin n_fail++; $display("FAIL release_fall t=%0d: got %h expected %h", t, FALL, 8'h00); end
    end
    I = 8'h00;
    for (int t = 1; t <= 4; t++) begin
      tick();
      n_checks++;
      if (O !== ((t >= 3) ? 8'h00 : 8'hFF)) begin
        n_fail++; $display("FAIL fall_o t=%0d: got %h expected %h", t, O, ((t >= 3) ? 8'h00 : 8'hFF));
      end
      n_checks++;
      if (FALL !== ((t == 3) ? 8'hFF : 8'h00)) begin
        n_fail++; $display("FAIL fall_pulse t=%0d: got %h expected %h", t, FALL, ((t == 3) ? 8'hFF : 8'h00));
      end
    end
  endtask

  // Combinational bypass, including while reset is held.
  task automatic test_bypass();
    CFG_REG = 8'h00; I = 8'h00;
    #1;
    n_checks++; if (O !== 8'h00) begin n_fail++; $display("FAIL bypass_low: got %h expected %h", O, 8'h00); end
    I = 8'h08;
    #1;
    n_checks++; if (O !== 8'h08) begin n_fail++; $display("FAIL bypass_high: got %h expected %h", O, 8'h08); end
    for (int t = 1; t <= 4; t++) begin
      tick();
      n_checks++; if (O !== 8'h08) begin n_fail++; $display("FAIL bypass_hold t=%0d: got %h expected %h", t, O, 8'h08); end
      n_checks++; if (RISE !== 8'h00) begin n_fail++; $display("FAIL bypass_rise t=%0d: got %h expected %h", t, RISE, 8'h00); end
      n_checks++; if (FALL !== 8'h00) begin n_fail++; $display("FAIL bypass_fall t=%0d: got %h expected %h", t, FALL, 8'h00); end
    end
    I = 8'h00;
    #1;
    n_checks++; if (O !== 8'h00) begin n_fail++; $display("FAIL bypass_back: got %h expected %h", O, 8'h00); end
    RST = 1'b1;
    #1;
    n_checks++; if (O !== 8'h00) begin n_fail++; $display("FAIL bypass_rst_low: got %h expected %h", O, 8'h00); end
    I = 8'h08;
    #1;
    n_checks++; if (O !== 8'h08) begin n_fail++; $display("FAIL bypass_rst_high: got %h expected %h", O, 8'h08); end
    I = 8'h00;
    tick();
    RST = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    CFG_REG = 8'hFF;
    #1;
    n_checks++; if (O !== 8'h00) begin n_fail++; $display("FAIL bypass_exit: got %h expected %h", O, 8'h00); end
  endtask

  // Glitch filter on channel 0 with L=3: 3-cycle pulse rejected, 4 accepted.
  task automatic test_filter_reject();
    logic [7:0] exp_o;
    CFG_FILT_EN = 8'h01; CFG_FILT_LEN = 4'd3;
    I = 8'h01;
    tick(); tick(); tick();
    I = 8'h00;
    for (int t = 1; t <= 8; t++) begin
      tick();
      n_checks++; if (O !== 8'h00) begin n_fail++; $display("FAIL reject_o t=%0d: got %h expected %h", t, O, 8'h00); end
      n_checks++; if (RISE !== 8'h00) begin n_fail++; $display("FAIL reject_rise t=%0d: got %h expected %h", t, RISE, 8'h00); end
    end
    I = 8'h01;
    for (int t = 1; t <= 11; t++) begin
      tick();
      exp_o = (t >= 6 && t <= 9) ? 8'h01 : 8'h00;
      n_checks++; if (O !== exp_o) begin n_fail++; $display("FAIL accept_o t=%0d: got %h expected %h", t, O, exp_o); end
      n_checks++;
      if (RISE !== ((t == 6) ? 8'h01 : 8'h00)) begin
        n_fail++; $display("FAIL accept_rise t=%0d: got %h expected %h", t, RISE, ((t == 6) ? 8'h01 : 8'h00));
      end
      n_checks++;
      if (FALL !== ((t == 10) ? 8'h01 : 8'h00)) begin
        n_fail++; $display("FAIL accept_fall t=%0d: got %h expected %h", t, FALL, ((t == 10) ? 8'h01 : 8'h00));
      end
      if (t == 4) I = 8'h00;
    end
  endtask

  // Lowering L below the running count on channel 1 accepts on the next edge.
  task automatic test_l_change();
    CFG_FILT_EN = 8'h02; CFG_FILT_LEN = 4'd10;
    I = 8'h02;
    for (int t = 1; t <= 9; t++) begin
      tick();
      n_checks++; if (O !== 8'h00) begin n_fail++; $display("FAIL lchg_wait_o t=%0d: got %h expected %h", t, O, 8'h00); end
      n_checks++; if (RISE !== 8'h00) begin n_fail++; $display("FAIL lchg_wait_rise t=%0d: got %h expected %h", t, RISE, 8'h00); end
    end
    CFG_FILT_LEN = 4'd2;
    tick();
    n_checks++; if (O !== 8'h02) begin n_fail++; $display("FAIL lchg_accept_o: got %h expected %h", O, 8'h02); end
    n_checks++; if (RISE !== 8'h02) begin n_fail++; $display("FAIL lchg_accept_rise: got %h expected %h", RISE, 8'h02); end
    tick();
    n_checks++; if (O !== 8'h02) begin n_fail++; $display("FAIL lchg_hold_o: got %h expected %h", O, 8'h02); end
    n_checks++; if (RISE !== 8'h00) begin n_fail++; $display("FAIL lchg_single_rise: got %h expected %h", RISE, 8'h00); end
    I = 8'h00; CFG_FILT_EN = 8'h00;
    for (int t = 0; t < 4; t++) tick();
  endtask

  // Channel 2 filtered to F=1 while bypassed, then switched to registered.
  task automatic test_mode_switch();
    CFG_REG = 8'h00; CFG_FILT_EN = 8'h04; CFG_FILT_LEN = 4'd1;
    I = 8'h04;
    for (int t = 1; t <= 6; t++) begin
      tick();
      n_checks++; if (RISE !== 8'h00) begin n_fail++; $display("FAIL mode_masked_rise t=%0d: got %h expected %h", t, RISE, 8'h00); end
    end
    CFG_REG = 8'h04; I = 8'h00;
    #1;
    n_checks++; if (O !== 8'h04) begin n_fail++; $display("FAIL mode_switch_o: got %h expected %h", O, 8'h04); end
    n_checks++; if (RISE !== 8'h00) begin n_fail++; $display("FAIL mode_switch_rise: got %h expected %h", RISE, 8'h00); end
    tick();
    n_checks++; if (O !== 8'h04) begin n_fail++; $display("FAIL mode_after_o: got %h expected %h", O, 8'h04); end
    n_checks++; if (RISE !== 8'h00) begin n_fail++; $display("FAIL mode_after_rise: got %h expected %h", RISE, 8'h00); end
    for (int t = 0; t < 6; t++) tick();
    n_checks++; if (O !== 8'h00) begin n_fail++; $display("FAIL mode_settle_o: got %h expected %h", O, 8'h00); end
    CFG_REG = 8'hFF; CFG_FILT_EN = 8'h00; CFG_FILT_LEN = 4'd0;
  endtask

  // Asynchronous reset while channels 0-3 are mid-count and 4-7 hold F=1.
  task automatic test_async_reset();
    I = 8'hF0;
    for (int t = 0; t < 4; t++) tick();
    n_checks++; if (O !== 8'hF0) begin n_fail++; $display("FAIL arst_pre_o: got %h expected %h", O, 8'hF0); end
    CFG_FILT_EN = 8'h0F; CFG_FILT_LEN = 4'd5;
    I = 8'hFF;
    for (int t = 0; t < 5; t++) tick();
    n_checks++; if (O !== 8'hF0) begin n_fail++; $display("FAIL arst_count_o: got %h expected %h", O, 8'hF0); end
    #3;
    RST = 1'b1;
    #1;
    n_checks++; if (O !== 8'h00) begin n_fail++; $display("FAIL arst_now_o: got %h expected %h", O, 8'h00); end
    n_checks++; if (RISE !== 8'h00) begin n_fail++; $display("FAIL arst_now_rise: got %h expected %h", RISE, 8'h00); end
    n_checks++; if (FALL !== 8'h00) begin n_fail++; $display("FAIL arst_now_fall: got %h expected %h", FALL, 8'h00); end
    tick();
    n_checks++; if (FALL !== 8'h00) begin n_fail++; $display("FAIL arst_edge_fall: got %h expected %h", FALL, 8'h00); end
    RST = 1'b0; CFG_FILT_EN = 8'hFF;
    for (int t = 1; t <= 9; t++) begin
      tick();
      n_checks++;
      if (O !== ((t >= 8) ? 8'hFF : 8'h00)) begin
        n_fail++; $display("FAIL arst_restart_o t=%0d: got %h expected %h", t, O, ((t >= 8) ? 8'hFF : 8'h00));
      end
      n_checks++;
      if (RISE !== ((t == 8) ? 8'hFF : 8'h00)) begin
        n_fail++; $display("FAIL arst_restart_rise t=%0d: got %h expected %h", t, RISE, ((t == 8) ? 8'hFF : 8'h00));
      end
      n_checks++; if (FALL !== 8'h00) begin n_fail++; $display("FAIL arst_restart_fall t=%0d: got %h expected %h", t, FALL, 8'h00); end
    end
  endtask

  // Largest filter length: the counter reaches 15 and accepts there.
  task automatic test_max_len();
    CFG_FILT_LEN = 4'd15;
    I = 8'hEF;
    for (int t = 1; t <= 19; t++) begin
      tick();
      n_checks++;
      if (O !== ((t >= 18) ? 8'hEF : 8'hFF)) begin
        n_fail++; $display("FAIL maxlen_o t=%0d: got %h expected %h", t, O, ((t >= 18) ? 8'hEF : 8'hFF));
      end
      n_checks++;
      if (FALL !== ((t == 18) ? 8'h10 : 8'h00)) begin
        n_fail++; $display("FAIL maxlen_fall t=%0d: got %h expected %h", t, FALL, ((t == 18) ? 8'h10 : 8'h00));
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_bypass();
    test_filter_reject();
    test_l_change();
    test_mode_switch();
    test_async_reset();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
